// File: rtl/mouse_pos_ctl.sv
// Frame-synchronous cursor position and rate-limited shot control.
// Optional 2-tap position jitter filter: define MOUSE_SMOOTH_EN.
module mouse_pos_ctl #(
  parameter int H_PIXELS        = 800,
  parameter int V_PIXELS        = 600,
  parameter int X_RST           = 400,
  parameter int Y_RST           = 300,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] xpos_raw,
  input  logic [11:0] ypos_raw,
  input  logic        left_raw,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        shot_valid,
  output logic [11:0] shot_x,
  output logic [11:0] shot_y,
  output logic        shot_ready,
  output logic [7:0]  shot_count
);

  typedef enum logic [1:0] {
    READY,
    FIRE,
    COOLDOWN,
    WAIT_REL
  } state_t;

  localparam logic [11:0] X_MAX = 12'(H_PIXELS - 1);
  localparam logic [11:0] Y_MAX = 12'(V_PIXELS - 1);
  localparam logic [11:0] X_INI = 12'(X_RST);
  localparam logic [11:0] Y_INI = 12'(Y_RST);
  localparam logic [7:0]  CD    = 8'(COOLDOWN_FRAMES);

  state_t      state;
  logic        vblnk_d;
  logic        frame_tick;
  logic        sync1;
  logic        left_s;
  logic        left_s_d;
  logic        press;
  logic [7:0]  cnt;
  logic [11:0] x_clamp;
  logic [11:0] y_clamp;
  logic [11:0] x_next;
  logic [11:0] y_next;

  assign frame_tick = vblnk & ~vblnk_d;
  assign press      = left_s & ~left_s_d;
  assign x_clamp    = (xpos_raw > X_MAX) ? X_MAX : xpos_raw;
  assign y_clamp    = (ypos_raw > Y_MAX) ? Y_MAX : ypos_raw;

`ifdef MOUSE_SMOOTH_EN
  logic [12:0] x_sum;
  logic [12:0] y_sum;

  assign x_sum  = {1'b0, xpos} + {1'b0, x_clamp};
  assign y_sum  = {1'b0, ypos} + {1'b0, y_clamp};
  assign x_next = x_sum[12:1];
  assign y_next = y_sum[12:1];
`else
  assign x_next = x_clamp;
  assign y_next = y_clamp;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_d  <= 1'b0;
      sync1    <= 1'b0;
      left_s   <= 1'b0;
      left_s_d <= 1'b0;
      xpos     <= X_INI;
      ypos     <= Y_INI;
    end else begin
      vblnk_d  <= vblnk;
      sync1    <= left_raw;
      left_s   <= sync1;
      left_s_d <= left_s;
      if (frame_tick) begin
        xpos <= x_next;
        ypos <= y_next;
      end
    end
  end

  // Capture happens at the end of FIRE, so it sees the pre-tick position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= READY;
      shot_valid <= 1'b0;
      shot_x     <= '0;
      shot_y     <= '0;
      shot_ready <= 1'b1;
      shot_count <= '0;
      cnt        <= '0;
    end else begin
      shot_valid <= 1'b0;
      unique case (state)
        READY: begin
          if (press) begin
            state      <= FIRE;
            shot_ready <= 1'b0;
          end
        end
        FIRE: begin
          shot_valid <= 1'b1;
          shot_x     <= xpos;
          shot_y     <= ypos;
          shot_count <= shot_count + 8'd1;
          cnt        <= '0;
          state      <= (CD == 8'd0) ? WAIT_REL : COOLDOWN;
        end
        COOLDOWN: begin
          if (frame_tick) begin
            cnt <= cnt + 8'd1;
            if (cnt + 8'd1 == CD) state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!left_s) begin
            state      <= READY;
            shot_ready <= 1'b1;
          end
        end
        default: begin
          state      <= READY;
          shot_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_pos_ctl.sv
// Directed bench for mouse_pos_ctl with a 2-frame cooldown.
module tb_mouse_pos_ctl;

  logic        clk;
  logic        rst_n;
  logic [11:0] xpos_raw;
  logic [11:0] ypos_raw;
  logic        left_raw;
  logic        vblnk;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        shot_valid;
  logic [11:0] shot_x;
  logic [11:0] shot_y;
  logic        shot_ready;
  logic [7:0]  shot_count;

  int vectors;
  int errors;
  int pulses;
  int p0;

  mouse_pos_ctl #(
    .COOLDOWN_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .xpos_raw  (xpos_raw),
    .ypos_raw  (ypos_raw),
    .left_raw  (left_raw),
    .vblnk     (vblnk),
    .xpos      (xpos),
    .ypos      (ypos),
    .shot_valid(shot_valid),
    .shot_x    (shot_x),
    .shot_y    (shot_y),
    .shot_ready(shot_ready),
    .shot_count(shot_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (shot_valid) pulses++;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vblnk = 1'b1;
    repeat (4) step();
    vblnk = 1'b0;
    repeat (4) step();
  endtask

  task automatic do_shot();
    left_raw = 1'b1;
    repeat (6) step();
    left_raw = 1'b0;
    frame();
    frame();
    step();
  endtask

  initial begin
    vectors  = 0;
    errors   = 0;
    pulses   = 0;
    rst_n    = 1'b1;
    xpos_raw = '0;
    ypos_raw = '0;
    left_raw = 1'b0;
    vblnk    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_xpos", int'(xpos), 400);
    check("rst_ypos", int'(ypos), 300);
    check("rst_ready", int'(shot_ready), 1);
    check("rst_count", int'(shot_count), 0);
    check("rst_valid", int'(shot_valid), 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    xpos_raw = 12'd123;
    ypos_raw = 12'd77;
    repeat (3) step();
    xpos_raw = 12'd456;
    step();
    check("hold_mid_frame", int'(xpos), 400);
    vblnk = 1'b1;
    step();
    check("sync_x", int'(xpos), 456);
    check("sync_y", int'(ypos), 77);
    xpos_raw = 12'd10;
    repeat (3) step();
    vblnk = 1'b0;
    step();
    check("hold_in_vblnk", int'(xpos), 456);
    repeat (3) step();

    xpos_raw = 12'd900;
    ypos_raw = 12'd4095;
    frame();
    check("clamp_x", int'(xpos), 799);
    check("clamp_y", int'(ypos), 599);
    xpos_raw = 12'd799;
    ypos_raw = 12'd598;
    frame();
    check("edge_x", int'(xpos), 799);
    check("edge_y", int'(ypos), 598);

    xpos_raw = 12'd200;
    ypos_raw = 12'd150;
    frame();
    p0 = pulses;
    left_raw = 1'b1;
    repeat (3) step();
    check("shot_early", int'(shot_valid), 0);
    step();
    check("shot1_valid", int'(shot_valid), 1);
    check("shot1_x", int'(shot_x), 200);
    check("shot1_y", int'(shot_y), 150);
    check("shot1_count", int'(shot_count), 1);
    check("shot1_ready", int'(shot_ready), 0);

    step();
    left_raw = 1'b0;
    repeat (4) step();
    left_raw = 1'b1;
    repeat (6) step();
    frame();
    frame();
    frame();
    check("no_repeat", pulses - p0, 1);
    check("held_count", int'(shot_count), 1);
    check("held_ready", int'(shot_ready), 0);
    check("held_x", int'(shot_x), 200);

    left_raw = 1'b0;
    repeat (5) step();
    check("rel_ready", int'(shot_ready), 1);
    left_raw = 1'b1;
    repeat (4) step();
    check("shot2_valid", int'(shot_valid), 1);
    check("shot2_count", int'(shot_count), 2);

    left_raw = 1'b0;
    frame();
    frame();
    step();
    xpos_raw = 12'd333;
    ypos_raw = 12'd222;
    left_raw = 1'b1;
    step();
    step();
    vblnk = 1'b1;
    step();
    step();
    check("same_valid", int'(shot_valid), 1);
    check("same_x", int'(shot_x), 333);
    check("same_y", int'(shot_y), 222);
    check("same_count", int'(shot_count), 3);
    vblnk = 1'b0;
    step();

    left_raw = 1'b0;
    frame();
    frame();
    step();
    check("pre4_ready", int'(shot_ready), 1);
    xpos_raw = 12'd50;
    ypos_raw = 12'd60;
    left_raw = 1'b1;
    repeat (3) step();
    vblnk = 1'b1;
    step();
    check("fire_tick_x", int'(shot_x), 333);
    check("fire_tick_y", int'(shot_y), 222);
    check("fire_tick_pos", int'(xpos), 50);
    check("fire_tick_count", int'(shot_count), 4);
    repeat (3) step();
    vblnk = 1'b0;
    repeat (4) step();
    left_raw = 1'b0;
    frame();
    repeat (3) step();
    check("uncounted_frame", int'(shot_ready), 0);
    frame();
    step();
    check("cool_done", int'(shot_ready), 1);

    p0 = pulses;
    repeat (251) do_shot();
    check("count_255", int'(shot_count), 255);
    do_shot();
    check("count_wrap", int'(shot_count), 0);
    check("wrap_pulses", pulses - p0, 252);

    left_raw = 1'b1;
    repeat (6) step();
    check("mid_cool_ready", int'(shot_ready), 0);
    check("mid_cool_count", int'(shot_count), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", int'(shot_count), 0);
    check("arst_ready", int'(shot_ready), 1);
    check("arst_xpos", int'(xpos), 400);
    check("arst_ypos", int'(ypos), 300);
    left_raw = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
